// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache to main-memory arbiter.
// Holds the FSM state encoding, the owner codes shown on arb_owner,
// the arbitration-mode selectors and the default bus widths.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10,
        GAP    = 2'b11
    } arb_state_t;

    // Encodings driven on arb_owner
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    // ARB_MODE selectors
    localparam int ARB_RR    = 0;  // round-robin between I and D
    localparam int ARB_DPRIO = 1;  // fixed priority, D wins ties

    // Default widths: block address is byte address [31:4], block is 16 bytes
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose : shares one slow memory port between the I-cache and D-cache block interfaces.
// Latency : request sampled in IDLE appears on mem_* next cycle; ready/rdata forwarded combinationally.
// Backpressure: one transaction at a time; loser keeps its request held until granted, GAP cycle between grants.
//
// Ports:
//   clk, proc_reset           - clock, synchronous active-high reset
//   memI_* / memD_*           - cache-side block read/write request, address, write data;
//                               rdata/ready returned to that cache only while it owns memory
//   mem_read/write/addr/wdata - registered request to the shared memory
//   mem_rdata, mem_ready      - memory response (ready is a one-cycle pulse)
//   arb_owner                 - 00 none, 01 I-cache, 10 D-cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              memI_read,
    input  logic              memI_write,
    input  logic [ADDR_W-1:0] memI_addr,
    input  logic [DATA_W-1:0] memI_wdata,
    output logic [DATA_W-1:0] memI_rdata,
    output logic              memI_ready,

    input  logic              memD_read,
    input  logic              memD_write,
    input  logic [ADDR_W-1:0] memD_addr,
    input  logic [DATA_W-1:0] memD_wdata,
    output logic [DATA_W-1:0] memD_rdata,
    output logic              memD_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [1:0]        arb_owner
);

    localparam logic P_D_PRIO = (ARB_MODE == ARB_DPRIO);

    arb_state_t        r_state;
    logic              r_last_d;     // last_grant: 0 = I, 1 = D
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_owner;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_d;
    logic w_done_i;
    logic w_done_d;

    assign w_req_i = memI_read | memI_write;
    assign w_req_d = memD_read | memD_write;

    // D wins when it is the only requester, when D has fixed priority,
    // or under round-robin when I was the most recent winner.
    assign w_pick_d = w_req_d & (~w_req_i | P_D_PRIO | ~r_last_d);

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_owner     <= OWN_NONE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_i | w_req_d) begin
                        if (w_pick_d) begin
                            r_mem_read  <= memD_read;
                            r_mem_write <= memD_write;
                            r_mem_addr  <= memD_addr;
                            r_mem_wdata <= memD_wdata;
                            r_last_d    <= 1'b1;
                            r_owner     <= OWN_D;
                            r_state     <= BUSY_D;
                        end else begin
                            r_mem_read  <= memI_read;
                            r_mem_write <= memI_write;
                            r_mem_addr  <= memI_addr;
                            r_mem_wdata <= memI_wdata;
                            r_last_d    <= 1'b0;
                            r_owner     <= OWN_I;
                            r_state     <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Cache inputs are ignored here; only the memory completion moves us on.
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_owner     <= OWN_NONE;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    // One dead cycle so the served cache can drop its request.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Completion is steered only to the current owner; a ready seen in
    // IDLE or GAP (stray, or late after a reset) never reaches a cache.
    assign w_done_i = (r_state == BUSY_I) & mem_ready;
    assign w_done_d = (r_state == BUSY_D) & mem_ready;

    assign memI_ready = w_done_i;
    assign memD_ready = w_done_d;
    assign memI_rdata = w_done_i ? mem_rdata : '0;
    assign memD_rdata = w_done_d ? mem_rdata : '0;

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign arb_owner = r_owner;

endmodule
